// File: rtl/mac_channel_acc.sv
// Pipelined, handshaked multi-channel window MAC.
// Each beat is a KxK feature/kernel product reduced to one window sum. CHANNELS
// consecutive window sums are accumulated onto a bias, and the total is emitted
// as one result, with optional ReLU.
module mac_channel_acc #(
    parameter int unsigned KERNEL_SIZE    = 3,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned FEATURE_SIGNED = 0,
    parameter int unsigned RELU           = 0,
    localparam int unsigned PRODUCT_WIDTH = 2 * DATA_WIDTH,
    localparam int unsigned SUM_WIDTH     = PRODUCT_WIDTH + $clog2(KERNEL_SIZE * KERNEL_SIZE),
    localparam int unsigned ACC_WIDTH     = SUM_WIDTH + $clog2(CHANNELS) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       feature [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
    input  logic signed [DATA_WIDTH-1:0] kernel [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
    input  logic signed [SUM_WIDTH-1:0] bias,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] result,
    output logic                        busy
);

    localparam int unsigned EXT_WIDTH = DATA_WIDTH + 1;
    localparam int unsigned MUL_WIDTH = PRODUCT_WIDTH + 1;
    localparam int unsigned CNT_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(CHANNELS - 1);

    logic                  stall;
    logic                  advance;
    logic                  in_xfer;
    logic [CNT_WIDTH-1:0]  count;
    logic                  beat_first;
    logic                  beat_last;

    logic signed [EXT_WIDTH-1:0]     fext_c [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1];
    logic signed [MUL_WIDTH-1:0]     mul_c  [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1];
    logic signed [PRODUCT_WIDTH-1:0] prod_c [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1];
    logic signed [SUM_WIDTH-1:0]     sum_c;

    logic                            s1_valid;
    logic                            s1_first;
    logic                            s1_last;
    logic signed [PRODUCT_WIDTH-1:0] s1_prod [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1];
    logic signed [SUM_WIDTH-1:0]     s1_bias;

    logic                        s2_valid;
    logic                        s2_first;
    logic                        s2_last;
    logic signed [SUM_WIDTH-1:0] s2_sum;
    logic signed [SUM_WIDTH-1:0] s2_bias;

    logic                        s3_last;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_base_c;

    // Handshake: a held, unaccepted result freezes the whole pipeline.
    assign stall      = out_valid & ~out_ready;
    assign advance    = ~stall;
    assign in_ready   = advance;
    assign in_xfer    = in_valid & advance;
    assign beat_first = (count == '0);
    assign beat_last  = (count == LAST_COUNT);
    assign busy       = s1_valid | s2_valid | s3_last | (count != '0) | out_valid;

    // Element-wise products; feature widened by one bit so unsigned values stay positive.
    always_comb begin
        for (int r = 0; r < int'(KERNEL_SIZE); r++) begin
            for (int c = 0; c < int'(KERNEL_SIZE); c++) begin
                fext_c[r][c] = (FEATURE_SIGNED != 0) ? {feature[r][c][DATA_WIDTH-1], feature[r][c]}
                                                     : {1'b0, feature[r][c]};
                mul_c[r][c]  = MUL_WIDTH'(fext_c[r][c]) * MUL_WIDTH'(kernel[r][c]);
                prod_c[r][c] = PRODUCT_WIDTH'(mul_c[r][c]);
            end
        end
    end

    // Adder tree over the registered products.
    always_comb begin
        sum_c = '0;
        for (int r = 0; r < int'(KERNEL_SIZE); r++) begin
            for (int c = 0; c < int'(KERNEL_SIZE); c++) begin
                sum_c = sum_c + SUM_WIDTH'(s1_prod[r][c]);
            end
        end
    end

    // The first beat of a group starts from the bias instead of the running total.
    always_comb begin
        acc_base_c = s2_first ? ACC_WIDTH'(s2_bias) : acc;
    end

    // Datapath registers without reset; they only matter while their valid bit is set.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_prod <= prod_c;
            if (in_valid && beat_first) begin
                s1_bias <= bias;
            end
            s2_sum  <= sum_c;
            s2_bias <= s1_bias;
        end
    end

    // Control, channel counter, accumulator and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s3_last   <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (advance) begin
            if (in_xfer) begin
                count <= beat_last ? '0 : count + CNT_WIDTH'(1);
            end
            s1_valid <= in_valid;
            s1_first <= beat_first;
            s1_last  <= beat_last;
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            if (s2_valid) begin
                acc <= acc_base_c + ACC_WIDTH'(s2_sum);
            end
            s3_last   <= s2_valid & s2_last;
            out_valid <= s3_last;
            if (s3_last) begin
                result <= ((RELU != 0) && (acc < 0)) ? '0 : acc;
            end
        end
    end

endmodule

// File: tb/tb_mac_channel_acc.sv
// Testbench for mac_channel_acc: table vectors, hand sequences and random groups
// checked against a plain-arithmetic group model.
module tb_mac_channel_acc;

    localparam int unsigned SW  = 20;
    localparam int unsigned AW2 = 22;
    localparam int unsigned AW1 = 21;

    typedef logic [7:0]        fwin_t [0:2][0:2];
    typedef logic signed [7:0] kwin_t [0:2][0:2];
    typedef struct {
        int fmode;
        int fval;
        int kval;
        int bias;
        int exp_a;
        int exp_r;
    } vec_t;

    logic clk;
    logic reset;

    logic                  in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    fwin_t                 feat_a;
    kwin_t                 ker_a;
    logic signed [SW-1:0]  bias_a;
    logic signed [AW2-1:0] res_a;
    logic                  in_ready_r, out_valid_r, busy_r;
    logic signed [AW2-1:0] res_r;

    logic                  in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s;
    fwin_t                 feat_s;
    kwin_t                 ker_s;
    logic signed [SW-1:0]  bias_s;
    logic signed [AW1-1:0] res_s;

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qr[$];
    int qs[$];
    int rx_a = 0;
    int rx_s = 0;
    bit stall_a_d = 1'b0;
    bit stall_r_d = 1'b0;
    vec_t tbl[8];

    mac_channel_acc #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .CHANNELS(2), .FEATURE_SIGNED(0), .RELU(0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .feature(feat_a), .kernel(ker_a), .bias(bias_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .result(res_a), .busy(busy_a));

    mac_channel_acc #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .CHANNELS(2), .FEATURE_SIGNED(0), .RELU(1)) dut_r (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_r),
        .feature(feat_a), .kernel(ker_a), .bias(bias_a), .out_valid(out_valid_r),
        .out_ready(out_ready_a), .result(res_r), .busy(busy_r));

    mac_channel_acc #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .CHANNELS(1), .FEATURE_SIGNED(1), .RELU(0)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .feature(feat_s), .kernel(ker_s), .bias(bias_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s), .result(res_s), .busy(busy_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: window dot product with plain integer arithmetic.
    function automatic int wsum(input fwin_t f, input kwin_t k, input bit fsigned);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += (fsigned ? int'($signed(f[i][j])) : int'(f[i][j])) * int'(k[i][j]);
        return s;
    endfunction

    function automatic int relu(input int x);
        return (x < 0) ? 0 : x;
    endfunction

    function automatic fwin_t mk_f(input int mode, input int val);
        fwin_t f;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                f[i][j] = (mode == 0) ? 8'(3 * i + j + 1) : 8'(val);
        return f;
    endfunction

    function automatic kwin_t mk_k(input int val);
        kwin_t k;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                k[i][j] = 8'(val);
        return k;
    endfunction

    function automatic fwin_t rand_f();
        fwin_t f;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                f[i][j] = 8'($urandom);
        return f;
    endfunction

    function automatic kwin_t rand_k();
        kwin_t k;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                k[i][j] = 8'($urandom);
        return k;
    endfunction

    function automatic int rand_bias();
        return int'($urandom_range(0, 1048575)) - 524288;
    endfunction

    // Called at a falling edge; returns at the falling edge after the transfer edge.
    task automatic beat_a(input fwin_t f, input kwin_t k, input int b);
        int guard = 0;
        feat_a = f;
        ker_a = k;
        bias_a = SW'(b);
        in_valid_a = 1'b1;
        #1;
        while (!in_ready_a && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("beat_accept_a", int'(guard < 200), 1);
        @(negedge clk);
        in_valid_a = 1'b0;
    endtask

    // Second beat carries a random bias that must be ignored.
    task automatic send_pair(input fwin_t f0, input kwin_t k0, input fwin_t f1, input kwin_t k1,
                             input int b, input int gap);
        beat_a(f0, k0, b);
        repeat (gap) @(negedge clk);
        beat_a(f1, k1, rand_bias());
    endtask

    task automatic push_group(input fwin_t f0, input kwin_t k0, input fwin_t f1, input kwin_t k1,
                              input int b);
        int total;
        total = b + wsum(f0, k0, 1'b0) + wsum(f1, k1, 1'b0);
        qa.push_back(total);
        qr.push_back(relu(total));
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((qa.size() != 0 || qr.size() != 0 || qs.size() != 0 || busy_a || busy_s) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(qa.size() == 0 && qr.size() == 0 && qs.size() == 0 && n < 500), 1);
    endtask

    // Output scoreboards for the CHANNELS=2 pair.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            stall_a_d = 1'b0;
            stall_r_d = 1'b0;
        end else begin
            if (stall_a_d) check("hold_valid_a", int'(out_valid_a), 1);
            if (stall_r_d) check("hold_valid_r", int'(out_valid_r), 1);
            if (out_valid_a) begin
                check("pending_a", int'(qa.size() > 0), 1);
                if (qa.size() > 0) begin
                    if (out_ready_a) begin
                        check("result_a", int'(res_a), qa.pop_front());
                        rx_a++;
                    end else begin
                        check("held_a", int'(res_a), qa[0]);
                    end
                end
            end
            if (out_valid_r) begin
                check("pending_r", int'(qr.size() > 0), 1);
                if (qr.size() > 0) begin
                    if (out_ready_a) check("result_r", int'(res_r), qr.pop_front());
                    else check("held_r", int'(res_r), qr[0]);
                end
            end
            stall_a_d = out_valid_a && !out_ready_a;
            stall_r_d = out_valid_r && !out_ready_a;
        end
    end

    // Output scoreboard for the CHANNELS=1 signed instance.
    always @(negedge clk) begin
        #1;
        if (!reset && out_valid_s && out_ready_s) begin
            check("pending_s", int'(qs.size() > 0), 1);
            if (qs.size() > 0) begin
                check("result_s", int'(res_s), qs.pop_front());
                rx_s++;
            end
        end
    end

    initial begin
        fwin_t f0, f1;
        kwin_t k0, k1;
        int rx0;
        bit rnd_done;

        tbl[0] = '{0,   0,    1,       10,     100,    100};
        tbl[1] = '{1, 255, -128,        0, -587520,      0};
        tbl[2] = '{1,   1,   -1,        5,     -13,      0};
        tbl[3] = '{1,   0,   77,       -7,      -7,      0};
        tbl[4] = '{1,   2,    3,        0,     108,    108};
        tbl[5] = '{0,   0,   -2,      100,     -80,      0};
        tbl[6] = '{1, 200,  127,  -524288,  -67088,      0};
        tbl[7] = '{1, 128,   -1,   524287,  521983, 521983};

        reset = 1'b1;
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        feat_a = mk_f(1, 0);
        ker_a = mk_k(0);
        bias_a = '0;
        in_valid_s = 1'b0;
        out_ready_s = 1'b1;
        feat_s = mk_f(1, 0);
        ker_s = mk_k(0);
        bias_s = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid_a), 0);
        check("rst_result", int'(res_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_in_ready", int'(in_ready_a), 1);
        check("rst_s_out_valid", int'(out_valid_s), 0);
        @(negedge clk);

        // Basic group and exact latency: out_valid high only three edges after the last beat.
        f0 = mk_f(0, 0);
        k0 = mk_k(1);
        qa.push_back(100);
        qr.push_back(100);
        beat_a(f0, k0, 10);
        beat_a(f0, k0, 999);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("latency_ov", int'(out_valid_a), (c == 3) ? 1 : 0);
            @(negedge clk);
        end

        // Table vectors, back to back.
        for (int v = 0; v < 8; v++) begin
            f0 = mk_f(tbl[v].fmode, tbl[v].fval);
            k0 = mk_k(tbl[v].kval);
            qa.push_back(tbl[v].exp_a);
            qr.push_back(tbl[v].exp_r);
            send_pair(f0, k0, f0, k0, tbl[v].bias, 0);
        end
        wait_drain("drain_table");

        // Signed features, one channel: a result every cycle.
        feat_s = mk_f(1, 255);
        ker_s = mk_k(2);
        bias_s = '0;
        repeat (6) qs.push_back(-18);
        for (int c = 0; c < 12; c++) begin
            in_valid_s = (c < 6);
            #1;
            check("s_in_ready", int'(in_ready_s), 1);
            check("s_stream_ov", int'(out_valid_s), (c >= 4 && c <= 9) ? 1 : 0);
            @(negedge clk);
        end
        in_valid_s = 1'b0;
        wait_drain("drain_s");
        check("s_count", rx_s, 6);

        // Backpressure: four groups streamed, first result held for five cycles.
        rx0 = rx_a;
        fork
            begin
                for (int g = 0; g < 4; g++) begin
                    f0 = rand_f(); k0 = rand_k(); f1 = rand_f(); k1 = rand_k();
                    push_group(f0, k0, f1, k1, g * 1000 - 1500);
                    send_pair(f0, k0, f1, k1, g * 1000 - 1500, 0);
                end
            end
            begin
                int n = 0;
                while (!out_valid_a && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_first_seen", int'(n < 200), 1);
                out_ready_a = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    #1;
                    check("bp_in_ready", int'(in_ready_a), 0);
                    @(negedge clk);
                end
                out_ready_a = 1'b1;
            end
        join
        wait_drain("drain_bp");
        check("bp_count", rx_a - rx0, 4);

        // Reset mid-group, then a fresh group with idle gaps.
        f0 = rand_f(); k0 = rand_k();
        beat_a(f0, k0, 12345);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid_a), 0);
        check("mid_rst_result", int'(res_a), 0);
        check("mid_rst_busy", int'(busy_a), 0);
        check("mid_rst_in_ready", int'(in_ready_a), 1);
        check("mid_rst_r_busy", int'(busy_r), 0);
        check("mid_rst_r_in_ready", int'(in_ready_r), 1);
        @(negedge clk);
        rx0 = rx_a;
        f0 = rand_f(); k0 = rand_k(); f1 = rand_f(); k1 = rand_k();
        push_group(f0, k0, f1, k1, -321);
        send_pair(f0, k0, f1, k1, -321, 2);
        wait_drain("drain_rst");
        check("rst_group_count", rx_a - rx0, 1);
        check("busy_after_group", int'(busy_a), 0);

        // Random groups with bubbles and random downstream readiness.
        rx0 = rx_a;
        rnd_done = 1'b0;
        fork
            begin
                for (int g = 0; g < 40; g++) begin
                    int b;
                    f0 = rand_f(); k0 = rand_k(); f1 = rand_f(); k1 = rand_k();
                    b = rand_bias();
                    push_group(f0, k0, f1, k1, b);
                    send_pair(f0, k0, f1, k1, b, int'($urandom_range(0, 2)));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready_a = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
                out_ready_a = 1'b1;
            end
        join
        wait_drain("drain_random");
        check("random_count", rx_a - rx0, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_channel_acc.md
Name: mac_channel_acc

Overview:
- Pipelined, handshaked successor to the combinational window MAC.
- Per accepted beat: multiplies a KERNEL_SIZE x KERNEL_SIZE feature window element-wise by a kernel window, then sums the products in an adder tree.
- Accumulates these window sums over CHANNELS consecutive beats, adds a bias, optionally applies ReLU, and emits one result per output pixel.
- Sits between the line-buffer/window generator and the output quantiser in the convolution datapath.

Parameters:
- KERNEL_SIZE, 3, window is KERNEL_SIZE x KERNEL_SIZE.
- DATA_WIDTH, 8, width of each feature and kernel element.
- CHANNELS, 4, input-channel windows accumulated per output (>=1).
- FEATURE_SIGNED, 0, 0: feature elements unsigned (zero-extended); 1: two's complement.
- RELU, 0, 1: negative final results clamp to 0.
- Derived: PRODUCT_WIDTH = 2*DATA_WIDTH; SUM_WIDTH = PRODUCT_WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE); ACC_WIDTH = SUM_WIDTH + $clog2(CHANNELS) + 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  feature/kernel/bias beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- feature  in  [DATA_WIDTH-1:0] x [0:K-1][0:K-1]  feature window; signedness per FEATURE_SIGNED.
- kernel  in  signed [DATA_WIDTH-1:0] x [0:K-1][0:K-1]  kernel window.
- bias  in  signed SUM_WIDTH  bias; sampled only on the first beat of a group.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  signed ACC_WIDTH  accumulated result.
- busy  out  1  high while any pipeline stage or partial accumulation is non-empty.

Behaviour:
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_valid/result remain stable until the output transfer completes.
- Global stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - On stall, all stage registers, valid bits, the channel counter and the accumulator hold.
- Stage 1 (S1): register the K*K signed products.
  - FEATURE_SIGNED=0: feature zero-extended to DATA_WIDTH+1 bits before multiply.
  - Every product fits PRODUCT_WIDTH signed.
- Stage 2 (S2): register the adder-tree sum, SUM_WIDTH signed.
- Stage 3 (S3): accumulator, ACC_WIDTH signed.
  - On a first-tagged beat: acc = sext(bias) + sext(sum).
  - Otherwise: acc = acc + sext(sum).
  - No overflow is possible by construction; no saturation logic.
- Channel counter: 0..CHANNELS-1, advances on each input transfer, wraps to 0 after CHANNELS-1.
  - Beat tagged first when count==0, last when count==CHANNELS-1; CHANNELS=1 sets both tags on every beat.
  - Tags and valid bits travel with data through S1/S2.
- Output:
  - When the last-tagged beat leaves S2 and updates S3, out_valid asserts on the next edge.
  - result = (RELU && acc<0) ? 0 : acc.
  - Latency: last beat accepted at edge N -> out_valid high after edge N+3.
- Throughput: one beat per cycle with out_ready held high; out_valid pulses once every CHANNELS beats.
- A first-tagged beat reaching S3 while the previous result is still held can only occur after the stall clears; the result register and accumulator are separate, so back-to-back groups need no bubble.
- in_valid low creates bubbles; counter and accumulator hold across bubbles. The group completes whenever the remaining beats arrive.
- Reset (any time, including mid-group or during stall): on the reset edge all valid bits, counter, accumulator and result clear.
  - Outputs after reset: out_valid=0, result=0, busy=0, in_ready=1.
  - A partial group is discarded.
- busy = any stage valid | counter!=0 | out_valid.

Test Plan:
- K=3, D=8, CHANNELS=2, FEATURE_SIGNED=0, RELU=0:
  - Stimulus: two beats with feature[i][j]=3i+j+1 (values 1..9), kernel all 1; bias=10 on first beat; out_ready=1.
  - Required: result=100, out_valid exactly 3 cycles after the second beat is accepted, high for 1 cycle.
- Same config, extreme magnitude:
  - Stimulus: features all 255, kernel all -128, bias 0, two beats.
  - Required: result=-587520 (22-bit), no wrap. With RELU=1 -> result=0.
- FEATURE_SIGNED=1, CHANNELS=1:
  - Stimulus: feature all 8'hFF (-1), kernel all 2, bias 0.
  - Required: result=-18 on every beat; continuous one-per-cycle output at full throughput.
- Backpressure:
  - Stimulus: stream 4 groups (CHANNELS=2) while holding out_ready=0 for 5 cycles after the first result.
  - Required: in_ready=0 while stalled, result held stable, all 4 results correct and in order, none lost or duplicated.
- Reset mid-group and bubbles:
  - Stimulus: accept 1 of 2 beats, assert reset 1 cycle, then send a fresh group with gaps of 2 idle cycles between beats.
  - Required: first partial beat discarded; single correct result from the new group; busy=0 after completion.
